// File: rtl/ir_scan_sequencer_if.sv
// Block-memory write port: request/grant handshake carrying one 16-bit word per grant.
interface ir_scan_sequencer_if;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_data;

  modport master (output mem_req, mem_we, mem_addr, mem_data, input mem_gnt);
  modport slave  (input mem_req, mem_we, mem_addr, mem_data, output mem_gnt);
endinterface

// File: rtl/ir_scan_sequencer.sv
// Servo sweep controller: per column it moves, settles, triggers a capture of 8 temperatures
// and writes them to block memory through a request/grant port.
module ir_scan_sequencer #(
  parameter logic [15:0] ANGLE_MIN      = 16'd0,
  parameter logic [15:0] ANGLE_MAX      = 16'd180,
  parameter logic [15:0] ANGLE_STEP     = 16'd15,
  parameter logic [23:0] SETTLE_CYCLES  = 24'd2_500_000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000,
  parameter logic [23:0] FRAME_BASE     = 24'h003000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  output logic [15:0]                servo_angle,
  output logic                       temps_en,
  input  logic                       temps_valid,
  input  logic [127:0]               temps_in,
  ir_scan_sequencer_if.master        mem,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [7:0]                 column
);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_SETTLE, S_TRIGGER, S_WAIT_VALID, S_WRITE, S_NEXT, S_DONE
  } state_e;

  state_e       state_q, state_d;
  logic [15:0]  angle_q, angle_d;
  logic [15:0]  servo_q, servo_d;
  logic [7:0]   column_q, column_d;
  logic [23:0]  cnt_q, cnt_d;
  logic [2:0]   pix_q, pix_d;
  logic [127:0] buf_q, buf_d;
  logic         stop_q, stop_d;
  logic         error_q, error_d;
  logic         temps_en_q, temps_en_d;
  logic         valid_prev_q;

  logic         valid_rise;
  logic [16:0]  next_angle;
  logic         req;

  assign valid_rise = temps_valid & ~valid_prev_q;
  // 17-bit sum so a step past 16'hFFFF still compares as larger than ANGLE_MAX.
  assign next_angle = {1'b0, angle_q} + {1'b0, ANGLE_STEP};

  // NOTE: every output of this block gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    angle_d    = angle_q;
    servo_d    = servo_q;
    column_d   = column_q;
    cnt_d      = cnt_q;
    pix_d      = pix_q;
    buf_d      = buf_q;
    stop_d     = stop_q;
    error_d    = error_q;
    temps_en_d = temps_en_q;
    req        = 1'b0;
    done       = 1'b0;

    if (state_q != S_IDLE && stop) stop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MOVE;
          error_d = 1'b0;
          stop_d  = stop;
        end
      end
      S_MOVE: begin
        servo_d = angle_q;
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q + 24'd1 >= SETTLE_CYCLES) state_d = S_TRIGGER;
        else                                cnt_d   = cnt_q + 24'd1;
      end
      S_TRIGGER: begin
        temps_en_d = 1'b1;
        cnt_d      = '0;
        state_d    = S_WAIT_VALID;
      end
      S_WAIT_VALID: begin
        if (valid_rise) begin
          buf_d      = temps_in;
          temps_en_d = 1'b0;
          pix_d      = '0;
          state_d    = S_WRITE;
        end else if (cnt_q + 24'd1 >= TIMEOUT_CYCLES) begin
          error_d    = 1'b1;
          temps_en_d = 1'b0;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_WRITE: begin
        req = 1'b1;
        if (mem.mem_gnt) begin
          if (pix_q == 3'd7) state_d = S_NEXT;
          else               pix_d   = pix_q + 3'd1;
        end
      end
      S_NEXT: begin
        if (stop_q || next_angle > {1'b0, ANGLE_MAX}) begin
          state_d = S_DONE;
        end else begin
          angle_d  = next_angle[15:0];
          column_d = column_q + 8'd1;
          state_d  = S_MOVE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        column_d = '0;
        angle_d  = ANGLE_MIN;
        stop_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      angle_q      <= ANGLE_MIN;
      servo_q      <= ANGLE_MIN;
      column_q     <= '0;
      cnt_q        <= '0;
      pix_q        <= '0;
      stop_q       <= 1'b0;
      error_q      <= 1'b0;
      temps_en_q   <= 1'b0;
      valid_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      angle_q      <= angle_d;
      servo_q      <= servo_d;
      column_q     <= column_d;
      cnt_q        <= cnt_d;
      pix_q        <= pix_d;
      stop_q       <= stop_d;
      error_q      <= error_d;
      temps_en_q   <= temps_en_d;
      valid_prev_q <= temps_valid;
    end
  end

  // NOTE: the capture buffer is data-only storage, always overwritten before it is read,
  // so it is deliberately left out of reset.
  always_ff @(posedge clock) begin
    buf_q <= buf_d;
  end

  assign mem.mem_req  = req;
  assign mem.mem_we   = req;
  assign mem.mem_addr = req ? FRAME_BASE + {13'd0, column_q, pix_q} : 24'd0;
  assign mem.mem_data = req ? buf_q[{pix_q, 4'b0000} +: 16] : 16'd0;

  assign servo_angle = servo_q;
  assign temps_en    = temps_en_q;
  assign busy        = (state_q != S_IDLE);
  assign error       = error_q;
  assign column      = column_q;

endmodule

// File: tb/tb_ir_scan_sequencer.sv
// Directed bench for ir_scan_sequencer: sweeps, grant stalls, timeout, stop, stale valid, reset.
module tb_ir_scan_sequencer;
  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic         temps_valid;
  logic [127:0] temps_in;
  logic [15:0]  servo_angle;
  logic         temps_en;
  logic         busy;
  logic         done;
  logic         error;
  logic [7:0]   column;

  ir_scan_sequencer_if mem_if();

  ir_scan_sequencer #(
    .ANGLE_MIN(16'd0), .ANGLE_MAX(16'd30), .ANGLE_STEP(16'd15),
    .SETTLE_CYCLES(24'd4), .TIMEOUT_CYCLES(24'd100), .FRAME_BASE(24'h003000)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .servo_angle(servo_angle), .temps_en(temps_en), .temps_valid(temps_valid),
    .temps_in(temps_in), .mem(mem_if), .busy(busy), .done(done), .error(error),
    .column(column)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor and grant generator.
  int          wr_count = 0, req_cycles = 0, done_count = 0, stall_seen = 0, stall_bad = 0;
  logic [23:0] wr_addr[$];
  logic [15:0] wr_data[$];
  logic        stalled = 1'b0;
  logic [23:0] held_addr;
  logic [15:0] held_data;
  int          stall_mode = 0;
  int          stall_cnt = 0;

  always @(posedge clock) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (done) done_count++;
      if (mem_if.mem_req) begin
        req_cycles++;
        if (stalled && (mem_if.mem_addr !== held_addr || mem_if.mem_data !== held_data))
          stall_bad++;
        if (mem_if.mem_gnt) begin
          wr_count++;
          wr_addr.push_back(mem_if.mem_addr);
          wr_data.push_back(mem_if.mem_data);
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          held_addr = mem_if.mem_addr;
          held_data = mem_if.mem_data;
          stall_seen++;
        end
      end else begin
        if (stalled) stall_bad++;
        stalled = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (stall_mode == 0) begin
      mem_if.mem_gnt = 1'b1;
    end else if (mem_if.mem_req) begin
      if (stall_cnt == 3) begin
        mem_if.mem_gnt = 1'b1;
        stall_cnt = 0;
      end else begin
        mem_if.mem_gnt = 1'b0;
        stall_cnt++;
      end
    end else begin
      mem_if.mem_gnt = 1'b0;
      stall_cnt = 0;
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  function automatic logic [127:0] pix(input int c);
    logic [127:0] v;
    for (int k = 0; k < 8; k++) v[16*k +: 16] = 16'(16'h0100 + 16 * c + k);
    return v;
  endfunction

  task automatic pulse(input int c);
    temps_in    = pix(c);
    temps_valid = 1'b1;
    tick();
    tick();
    temps_valid = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    int n;
    n = 0;
    while (temps_en !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check({tag, "_temps_en_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic capture_column(input int c);
    wait_en($sformatf("col%0d", c));
    check($sformatf("servo_col%0d", c), servo_angle, 64'(15 * c));
    check($sformatf("column_col%0d", c), column, 64'(c));
    repeat (10) tick();
    pulse(c);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) check({tag, "_idle_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic check_writes(input string tag, input int first, input int n, input int col0);
    for (int i = 0; i < n; i++) begin
      int g;
      logic [39:0] obs;
      logic [39:0] exp;
      g   = col0 * 8 + i;
      obs = {wr_addr[first + i], wr_data[first + i]};
      exp = {24'(24'h003000 + g), 16'(16'h0100 + 16 * (g / 8) + g % 8)};
      check($sformatf("%s_wr%0d", tag, i), obs, exp);
    end
  endtask

  task automatic kick_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, d0, s0, n;

    reset = 1'b1; start = 1'b0; stop = 1'b0; temps_valid = 1'b0; temps_in = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_servo", servo_angle, 0);
    check("rst_temps_en", temps_en, 0);
    check("rst_mem_req", mem_if.mem_req, 0);
    check("rst_mem_we", mem_if.mem_we, 0);
    check("rst_mem_addr", mem_if.mem_addr, 0);
    check("rst_mem_data", mem_if.mem_data, 0);
    check("rst_column", column, 0);

    // Full sweep with permanent grant.
    w0 = wr_count; r0 = req_cycles; d0 = done_count;
    kick_start();
    check("sweep_busy_after_start", busy, 1);
    n = 0;
    while (temps_en !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("sweep_temps_en_latency", n, 6);
    check("servo_col0", servo_angle, 0);
    repeat (10) tick();
    pulse(0);
    capture_column(1);
    capture_column(2);
    wait_idle("sweep");
    check("sweep_writes", wr_count - w0, 24);
    check("sweep_req_cycles", req_cycles - r0, 24);
    check("sweep_done_pulses", done_count - d0, 1);
    check("sweep_error", error, 0);
    check("sweep_servo_final", servo_angle, 30);
    check_writes("sweep", w0, 24, 0);

    // Sweep with three stall cycles ahead of every grant.
    stall_mode = 1;
    w0 = wr_count; r0 = req_cycles; s0 = stall_seen;
    kick_start();
    capture_column(0);
    capture_column(1);
    capture_column(2);
    wait_idle("stall");
    stall_mode = 0;
    check("stall_writes", wr_count - w0, 24);
    check("stall_cycles", stall_seen - s0, 72);
    check("stall_req_cycles", req_cycles - r0, 96);
    check("stall_stable", stall_bad, 0);
    check_writes("stall", w0, 24, 0);

    // Capture timeout: temps_valid never rises.
    r0 = req_cycles; d0 = done_count;
    kick_start();
    wait_en("timeout");
    repeat (99) tick();
    check("timeout_error_early", error, 0);
    check("timeout_en_held", temps_en, 1);
    tick();
    check("timeout_error_set", error, 1);
    check("timeout_done", done, 1);
    check("timeout_en_drop", temps_en, 0);
    tick();
    check("timeout_idle", busy, 0);
    check("timeout_error_sticky", error, 1);
    check("timeout_no_req", req_cycles - r0, 0);
    check("timeout_done_pulses", done_count - d0, 1);

    // Restart clears error; stop during column 0 settle ends after that column.
    w0 = wr_count; d0 = done_count;
    kick_start();
    check("restart_error_clear", error, 0);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    capture_column(0);
    wait_idle("stop");
    check("stop_writes", wr_count - w0, 8);
    check("stop_servo", servo_angle, 0);
    check("stop_done_pulses", done_count - d0, 1);
    check("stop_error", error, 0);
    check_writes("stop", w0, 8, 0);

    // temps_valid already high when the capture is triggered.
    w0 = wr_count; r0 = req_cycles;
    temps_in    = {8{16'hDEAD}};
    temps_valid = 1'b1;
    kick_start();
    wait_en("stale");
    repeat (5) tick();
    check("stale_en_held", temps_en, 1);
    check("stale_no_req", req_cycles - r0, 0);
    temps_valid = 1'b0;
    tick();
    tick();
    pulse(0);
    capture_column(1);
    capture_column(2);
    wait_idle("stale");
    check("stale_writes", wr_count - w0, 24);
    check_writes("stale", w0, 24, 0);

    // Reset while column 1 pixel 3 is being written.
    w0 = wr_count;
    kick_start();
    capture_column(0);
    capture_column(1);
    n = 0;
    while (!(mem_if.mem_req === 1'b1 && mem_if.mem_addr === 24'h00300B) && n < 40) begin
      tick();
      n++;
    end
    check("rstmid_reached_p3", (n < 40), 1);
    check("rstmid_data_p3", mem_if.mem_data, 16'h0113);
    reset = 1'b1;
    tick();
    check("rstmid_req", mem_if.mem_req, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_servo", servo_angle, 0);
    check("rstmid_column", column, 0);
    check("rstmid_temps_en", temps_en, 0);
    reset = 1'b0;
    repeat (30) tick();
    check("rstmid_writes", wr_count - w0, 11);
    check("rstmid_still_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
